commit_watchdog: RTL and testbench

COMMIT_WATCHDOG -- requirements
Module: commit_watchdog

---
 rtl/commit_watchdog.sv | 205 ++++++++++++++++++++
 tb/tb_commit_watchdog.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/commit_watchdog.sv
// commit_watchdog -- retire-stream watchdog for a simulation harness.
//
// Watches up to NUM_COMMIT retire channels per cycle and raises a sticky halt
// request when the program halts, the retire order tags go wrong, one PC
// repeats LOOP_THRESH times in a row, nothing retires for STALL_LIMIT enabled
// cycles, or TIMEOUT enabled cycles have elapsed.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   enable          : low = hold every piece of state, no detection
//   commit          : per-channel retire valid (must be a prefix from ch 0)
//   order           : per-channel order tag, ch i at [i*ORDER_WIDTH +: ORDER_WIDTH]
//   pc_rdata        : per-channel retired PC, ch i at [i*32 +: 32]
//   halt_in         : per-channel program-halt flag (qualified by commit)
//   halt            : sticky halt request
//   halt_cause      : 0 none, 1 program, 2 order, 3 loop, 4 stall, 5 timeout
//   halt_pc         : last committed PC (frozen once halted)
//   commit_count    : saturating count of retired instructions
//   cycle_count     : saturating count of enabled cycles

// Per-channel order tag check: channel k must carry expected_order + k.
module commit_watchdog_lane #(
    parameter int ORDER_WIDTH = 64,
    parameter int LANE        = 0
) (
    input  logic                   commit,
    input  logic [ORDER_WIDTH-1:0] order,
    input  logic [ORDER_WIDTH-1:0] expected_order,
    output logic                   order_err
);
    assign order_err = commit && (order != expected_order + ORDER_WIDTH'(LANE));
endmodule

module commit_watchdog #(
    parameter int          NUM_COMMIT  = 2,
    parameter int          ORDER_WIDTH = 64,
    parameter int          CNT_WIDTH   = 32,
    parameter int          LOOP_THRESH = 2047,
    parameter int          STALL_LIMIT = 10000,
    parameter int          TIMEOUT     = 100000000,
    parameter logic [31:0] RESET_PC    = 32'h00000060
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic [NUM_COMMIT-1:0]             commit,
    input  logic [NUM_COMMIT*ORDER_WIDTH-1:0] order,
    input  logic [NUM_COMMIT*32-1:0]          pc_rdata,
    input  logic [NUM_COMMIT-1:0]             halt_in,
    output logic                              halt,
    output logic [2:0]                        halt_cause,
    output logic [31:0]                       halt_pc,
    output logic [CNT_WIDTH-1:0]              commit_count,
    output logic [CNT_WIDTH-1:0]              cycle_count
);

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_PROGRAM = 3'd1,
        CAUSE_ORDER   = 3'd2,
        CAUSE_LOOP    = 3'd3,
        CAUSE_STALL   = 3'd4,
        CAUSE_TIMEOUT = 3'd5
    } cause_e;

    localparam logic [CNT_WIDTH-1:0] LOOP_LIM    = CNT_WIDTH'(LOOP_THRESH);
    localparam logic [CNT_WIDTH-1:0] STALL_LIM   = CNT_WIDTH'(STALL_LIMIT);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LIM = CNT_WIDTH'(TIMEOUT);

    // Saturating add: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [2:0]           b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + (CNT_WIDTH+1)'(b);
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    logic [NUM_COMMIT-1:0][ORDER_WIDTH-1:0] order_lane;
    logic [NUM_COMMIT-1:0][31:0]            pc_lane;
    logic [NUM_COMMIT-1:0]                  lane_err;

    assign order_lane = order;
    assign pc_lane    = pc_rdata;

    logic                   halt_q, halt_d;
    cause_e                 cause_q, cause_d;
    logic [CNT_WIDTH-1:0]   commit_count_q, commit_count_d;
    logic [CNT_WIDTH-1:0]   cycle_count_q, cycle_count_d;
    logic [CNT_WIDTH-1:0]   stall_q, stall_d;
    logic [CNT_WIDTH-1:0]   repeat_q, repeat_d;
    logic [ORDER_WIDTH-1:0] expected_order_q, expected_order_d;
    logic [31:0]            last_pc_q, last_pc_d;

    for (genvar i = 0; i < NUM_COMMIT; i++) begin : g_lane
        commit_watchdog_lane #(
            .ORDER_WIDTH(ORDER_WIDTH),
            .LANE       (i)
        ) u_lane (
            .commit        (commit[i]),
            .order         (order_lane[i]),
            .expected_order(expected_order_q),
            .order_err     (lane_err[i])
        );
    end

    logic                 gap, order_err, prog, loop_hit;
    logic [2:0]           pop;
    logic [CNT_WIDTH-1:0] rep, stall_n, cycle_n;
    logic [31:0]          lp;

    always_comb begin
        halt_d           = halt_q;
        cause_d          = cause_q;
        commit_count_d   = commit_count_q;
        cycle_count_d    = cycle_count_q;
        stall_d          = stall_q;
        repeat_d         = repeat_q;
        expected_order_d = expected_order_q;
        last_pc_d        = last_pc_q;

        // A valid above an invalid channel breaks the prefix rule.
        gap = 1'b0;
        for (int i = 1; i < NUM_COMMIT; i++) begin
            if (commit[i] && !commit[i-1]) gap = 1'b1;
        end
        order_err = gap | (|lane_err);

        pop = '0;
        for (int i = 0; i < NUM_COMMIT; i++) pop = pop + 3'(commit[i]);

        // Walk channels in index order so same-cycle repeats chain correctly.
        rep      = repeat_q;
        lp       = last_pc_q;
        prog     = 1'b0;
        loop_hit = 1'b0;
        for (int i = 0; i < NUM_COMMIT; i++) begin
            if (commit[i]) begin
                rep = (pc_lane[i] == lp) ? sat_add(rep, 3'd1) : '0;
                lp  = pc_lane[i];
                if (rep >= LOOP_LIM) loop_hit = 1'b1;
                if (halt_in[i])      prog     = 1'b1;
            end
        end

        stall_n = (commit == '0) ? sat_add(stall_q, 3'd1) : '0;
        cycle_n = sat_add(cycle_count_q, 3'd1);

        // Once halted everything freezes until reset.
        if (enable && !halt_q) begin
            commit_count_d   = sat_add(commit_count_q, pop);
            cycle_count_d    = cycle_n;
            stall_d          = stall_n;
            repeat_d         = rep;
            last_pc_d        = lp;
            expected_order_d = expected_order_q + ORDER_WIDTH'(pop);

            if (order_err) begin
                halt_d  = 1'b1;
                cause_d = CAUSE_ORDER;
            end else if (prog) begin
                halt_d  = 1'b1;
                cause_d = CAUSE_PROGRAM;
            end else if (loop_hit) begin
                halt_d  = 1'b1;
                cause_d = CAUSE_LOOP;
            end else if (stall_n >= STALL_LIM) begin
                halt_d  = 1'b1;
                cause_d = CAUSE_STALL;
            end else if (cycle_n >= TIMEOUT_LIM) begin
                halt_d  = 1'b1;
                cause_d = CAUSE_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_q           <= 1'b0;
            cause_q          <= CAUSE_NONE;
            commit_count_q   <= '0;
            cycle_count_q    <= '0;
            stall_q          <= '0;
            repeat_q         <= '0;
            expected_order_q <= '0;
            last_pc_q        <= RESET_PC;
        end else begin
            halt_q           <= halt_d;
            cause_q          <= cause_d;
            commit_count_q   <= commit_count_d;
            cycle_count_q    <= cycle_count_d;
            stall_q          <= stall_d;
            repeat_q         <= repeat_d;
            expected_order_q <= expected_order_d;
            last_pc_q        <= last_pc_d;
        end
    end

    // last_pc freezes with the halt, so it doubles as the reported halt PC.
    assign halt         = halt_q;
    assign halt_cause   = cause_q;
    assign halt_pc      = last_pc_q;
    assign commit_count = commit_count_q;
    assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_commit_watchdog.sv
// tb_commit_watchdog -- scoreboard bench for commit_watchdog.
// Two instances share the stimulus: dut A (LOOP_THRESH=4, STALL_LIMIT=8) for
// most scenarios, dut B (STALL_LIMIT=10, TIMEOUT=10) for the timeout ones.
// Each driven cycle pushes its expected post-edge outputs; a negedge monitor
// pops and compares them.
module tb_commit_watchdog;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic [1:0]   commit = '0;
    logic [127:0] order = '0;
    logic [63:0]  pc_rdata = '0;
    logic [1:0]   halt_in = '0;

    logic         a_halt, b_halt;
    logic [2:0]   a_cause, b_cause;
    logic [31:0]  a_pc, b_pc, a_cc, b_cc, a_cyc, b_cyc;

    always #5 clk = ~clk;

    commit_watchdog #(.NUM_COMMIT(2), .LOOP_THRESH(4), .STALL_LIMIT(8), .TIMEOUT(1000)) u_dut_a (
        .clk(clk), .rst(rst), .enable(enable), .commit(commit), .order(order),
        .pc_rdata(pc_rdata), .halt_in(halt_in), .halt(a_halt), .halt_cause(a_cause),
        .halt_pc(a_pc), .commit_count(a_cc), .cycle_count(a_cyc));

    commit_watchdog #(.NUM_COMMIT(2), .STALL_LIMIT(10), .TIMEOUT(10)) u_dut_b (
        .clk(clk), .rst(rst), .enable(enable), .commit(commit), .order(order),
        .pc_rdata(pc_rdata), .halt_in(halt_in), .halt(b_halt), .halt_cause(b_cause),
        .halt_pc(b_pc), .commit_count(b_cc), .cycle_count(b_cyc));

    typedef struct {
        string       tag;
        bit          sel;
        bit          h;
        logic [2:0]  c;
        logic [31:0] pc;
        int          cc;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_cc = 0;
    int   exp_cyc = 0;
    bit   exp_halted = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            check({cur.tag, ".halt"},  cur.sel ? 64'(b_halt)  : 64'(a_halt),  64'(cur.h));
            check({cur.tag, ".cause"}, cur.sel ? 64'(b_cause) : 64'(a_cause), 64'(cur.c));
            check({cur.tag, ".pc"},    cur.sel ? 64'(b_pc)    : 64'(a_pc),    64'(cur.pc));
            check({cur.tag, ".cc"},    cur.sel ? 64'(b_cc)    : 64'(a_cc),    64'(cur.cc));
            check({cur.tag, ".cyc"},   cur.sel ? 64'(b_cyc)   : 64'(a_cyc),   64'(cur.cyc));
        end
    end

    // Drive one cycle and queue what the selected dut must show after the edge.
    task automatic step(input bit en, input logic [1:0] cm, input int o0, input int o1,
                        input logic [31:0] p0, input logic [31:0] p1, input logic [1:0] hi,
                        input bit eh, input logic [2:0] ec, input logic [31:0] epc,
                        input string tag, input bit sel = 1'b0);
        exp_t e;
        @(negedge clk); #1;
        enable   = en;
        commit   = cm;
        order    = {64'(o1), 64'(o0)};
        pc_rdata = {p1, p0};
        halt_in  = hi;
        if (en && !exp_halted) begin
            exp_cyc++;
            exp_cc += int'(cm[0]) + int'(cm[1]);
        end
        exp_halted = eh;
        e = '{tag, sel, eh, ec, epc, exp_cc, exp_cyc};
        sb.push_back(e);
    endtask

    // Assert reset between edges and check it takes effect without a clock.
    task automatic do_reset(input string tag);
        @(negedge clk); #1;
        rst = 1'b1; enable = 1'b0; commit = '0; halt_in = '0;
        #1;
        check({tag, ".rst_halt"},  64'(a_halt),  64'd0);
        check({tag, ".rst_cause"}, 64'(a_cause), 64'd0);
        check({tag, ".rst_pc"},    64'(a_pc),    64'h60);
        check({tag, ".rst_cc"},    64'(a_cc),    64'd0);
        check({tag, ".rst_cyc"},   64'(a_cyc),   64'd0);
        check({tag, ".rst_bcyc"},  64'(b_cyc),   64'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        exp_cc = 0; exp_cyc = 0; exp_halted = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        do_reset("init");

        // Program halt on channel 0 with order 4, five commits total.
        step(1, 2'b11, 0, 1, 32'h200, 32'h204, 2'b00, 0, 0, 32'h204, "prog1");
        step(1, 2'b11, 2, 3, 32'h208, 32'h20c, 2'b00, 0, 0, 32'h20c, "prog2");
        step(1, 2'b01, 4, 0, 32'h210, 32'h0,   2'b01, 1, 1, 32'h210, "prog3");
        step(1, 2'b11, 5, 6, 32'h214, 32'h218, 2'b00, 1, 1, 32'h210, "prog_sticky");
        do_reset("r1");

        // Order tag skip.
        step(1, 2'b01, 0, 0, 32'h300, 32'h0, 2'b00, 0, 0, 32'h300, "ord1");
        step(1, 2'b01, 2, 0, 32'h304, 32'h0, 2'b00, 1, 2, 32'h304, "ord2");
        do_reset("r2");

        // Gap in the valid prefix (order tag itself is right).
        step(1, 2'b10, 0, 1, 32'h0, 32'h400, 2'b00, 1, 2, 32'h400, "gap");
        do_reset("r3");

        // Order error outranks a program halt in the same cycle.
        step(1, 2'b01, 7, 0, 32'h480, 32'h0, 2'b01, 1, 2, 32'h480, "prio");
        do_reset("r4");

        // Same PC five times: fourth repeat reaches LOOP_THRESH=4.
        for (int i = 0; i < 5; i++)
            step(1, 2'b01, i, 0, 32'h100, 32'h0, 2'b00, i == 4, (i == 4) ? 3'd3 : 3'd0,
                 32'h100, "loop5");
        do_reset("r5");

        // Four times then a new PC: no halt.
        for (int i = 0; i < 4; i++)
            step(1, 2'b01, i, 0, 32'h100, 32'h0, 2'b00, 0, 0, 32'h100, "loop4");
        step(1, 2'b01, 4, 0, 32'h104, 32'h0, 2'b00, 0, 0, 32'h104, "loop_break");
        step(1, 2'b01, 5, 0, 32'h104, 32'h0, 2'b00, 0, 0, 32'h104, "loop_after");
        do_reset("r6");

        // Stall: halt after the 8th idle enabled cycle.
        for (int i = 0; i < 8; i++)
            step(1, 2'b00, 0, 0, 0, 0, 2'b00, i == 7, (i == 7) ? 3'd4 : 3'd0, 32'h60, "stall8");
        do_reset("r7");

        // Commit on cycle 7 restarts the stall count.
        for (int i = 0; i < 6; i++)
            step(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 32'h60, "stall_pre");
        step(1, 2'b01, 0, 0, 32'h500, 32'h0, 2'b00, 0, 0, 32'h500, "stall_commit");
        for (int i = 0; i < 8; i++)
            step(1, 2'b00, 0, 0, 0, 0, 2'b00, i == 7, (i == 7) ? 3'd4 : 3'd0, 32'h500, "stall_post");
        do_reset("r8");

        // Enable low for 3 cycles holds the stall count.
        for (int i = 0; i < 4; i++)
            step(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 32'h60, "en_a");
        for (int i = 0; i < 3; i++)
            step(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 32'h60, "en_off");
        for (int i = 0; i < 4; i++)
            step(1, 2'b00, 0, 0, 0, 0, 2'b00, i == 3, (i == 3) ? 3'd4 : 3'd0, 32'h60, "en_b");
        do_reset("r9");

        // Reset mid-stall clears immediately; count restarts from zero.
        for (int i = 0; i < 5; i++)
            step(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 32'h60, "mid_pre");
        do_reset("mid_rst");
        for (int i = 0; i < 8; i++)
            step(1, 2'b00, 0, 0, 0, 0, 2'b00, i == 7, (i == 7) ? 3'd4 : 3'd0, 32'h60, "mid_post");
        do_reset("r10");

        // dut B: stall and timeout coincide, stall wins.
        for (int i = 0; i < 10; i++)
            step(1, 2'b00, 0, 0, 0, 0, 2'b00, i == 9, (i == 9) ? 3'd4 : 3'd0, 32'h60, "b_stall", 1'b1);
        do_reset("r11");

        // dut B: steady commits, timeout fires on the 10th cycle.
        for (int i = 0; i < 10; i++)
            step(1, 2'b11, 2*i, 2*i+1, 32'h1000 + 32'(8*i), 32'h1004 + 32'(8*i), 2'b00,
                 i == 9, (i == 9) ? 3'd5 : 3'd0, 32'h1004 + 32'(8*i), "b_timeout", 1'b1);

        @(negedge clk); #1;
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
